// File: rtl/switch_bounce_emulator_pkg.sv
// Shared types and constants for the switch bounce emulator: FSM states and
// the LFSR geometry used to generate contact chatter.
package switch_bounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    SETTLE
  } state_t;

  localparam int LFSR_W = 16;
  // Feedback taps at bits 15, 13, 12, 10 realise x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/switch_bounce_emulator_if.sv
// Bundle between a stimulus driver (master) and the bounce emulator (slave).
interface switch_bounce_emulator_if;

  logic       req_level;
  logic       sw_out;
  logic       busy;
  logic       stable_level;
  logic [7:0] edge_count;

  modport master (
    output req_level,
    input  sw_out,
    input  busy,
    input  stable_level,
    input  edge_count
  );

  modport slave (
    input  req_level,
    output sw_out,
    output busy,
    output stable_level,
    output edge_count
  );

endinterface

// File: rtl/switch_bounce_emulator_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; shifts left with the XOR of the tapped
// bits entering at bit 0.
module lfsr16
  import switch_bounce_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else begin
      state <= {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/switch_bounce_emulator.sv
// Turns a clean requested level into a chattering switch line: pseudo-random
// bounce ticks, then a settle hold, then the new level becomes stable.
module switch_bounce_emulator
  import switch_bounce_pkg::*;
#(
  parameter int                TICK_M       = 50_000,
  parameter int                BOUNCE_TICKS = 8,
  parameter int                SETTLE_TICKS = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  switch_bounce_emulator_if.slave  bus
);

  localparam int TW = $clog2(TICK_M);
  localparam int BW = $clog2(BOUNCE_TICKS + 1);
  localparam int SW = $clog2(SETTLE_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_M - 1);
  localparam logic [BW-1:0] B_LOAD    = BW'(BOUNCE_TICKS);
  localparam logic [BW-1:0] B_ONE     = BW'(1);
  localparam logic [SW-1:0] S_LOAD    = SW'(SETTLE_TICKS);
  localparam logic [SW-1:0] S_ONE     = SW'(1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic              target_q, target_d;
  logic              sw_q, sw_d;
  logic              stable_q, stable_d;
  logic              busy_q, busy_d;
  logic [7:0]        ecnt_q, ecnt_d;
  logic [LFSR_W-1:0] lfsr;
  logic              tick;
  logic              unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

  // Only the low bit drives chatter; the rest is the generator's internal state.
  assign unused_lfsr = ^lfsr[LFSR_W-1:1];
  assign tick        = (tick_cnt_q == TICK_LAST);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    bcnt_d     = bcnt_q;
    scnt_d     = scnt_q;
    target_d   = target_q;
    sw_d       = sw_q;
    stable_d   = stable_q;
    ecnt_d     = ecnt_q;

    case (state_q)
      IDLE: begin
        sw_d = stable_q;
        if (bus.req_level != stable_q) begin
          target_d   = bus.req_level;
          bcnt_d     = B_LOAD;
          ecnt_d     = '0;
          tick_cnt_d = '0;
          state_d    = BOUNCE;
        end
      end
      BOUNCE: begin
        if (tick) begin
          bcnt_d = bcnt_q - 1'b1;
          // The last bounce tick must win over the first when BOUNCE_TICKS is 1.
          if (bcnt_q == B_ONE) begin
            sw_d    = target_q;
            scnt_d  = S_LOAD;
            state_d = SETTLE;
          end else if (bcnt_q == B_LOAD) begin
            sw_d = target_q;
          end else begin
            sw_d = lfsr[0];
          end
        end
      end
      SETTLE: begin
        sw_d = target_q;
        if (tick) begin
          scnt_d = scnt_q - 1'b1;
          if (scnt_q == S_ONE) begin
            stable_d = target_q;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && (sw_d != sw_q)) begin
      ecnt_d = sat_inc(ecnt_q);
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bcnt_q     <= '0;
      scnt_q     <= '0;
      target_q   <= 1'b0;
      sw_q       <= 1'b0;
      stable_q   <= 1'b0;
      busy_q     <= 1'b0;
      ecnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bcnt_q     <= bcnt_d;
      scnt_q     <= scnt_d;
      target_q   <= target_d;
      sw_q       <= sw_d;
      stable_q   <= stable_d;
      busy_q     <= busy_d;
      ecnt_q     <= ecnt_d;
    end
  end

  assign bus.sw_out       = sw_q;
  assign bus.busy         = busy_q;
  assign bus.stable_level = stable_q;
  assign bus.edge_count   = ecnt_q;

endmodule

// File: tb/tb_switch_bounce_emulator.sv
// Directed bench for switch_bounce_emulator: three configurations share one
// clock and reset; a timing-based model covers the randomised request run.
module tb_switch_bounce_emulator;
  import switch_bounce_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference chatter generator, reset on the same edges as the DUTs.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  switch_bounce_emulator_if if_a ();
  switch_bounce_emulator_if if_b ();
  switch_bounce_emulator_if if_c ();

  switch_bounce_emulator #(.TICK_M(4), .BOUNCE_TICKS(3), .SETTLE_TICKS(2)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a));
  switch_bounce_emulator #(.TICK_M(4), .BOUNCE_TICKS(1), .SETTLE_TICKS(2)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b));
  switch_bounce_emulator #(.TICK_M(2), .BOUNCE_TICKS(8), .SETTLE_TICKS(4)) dut_c (
    .clk(clk), .reset(reset), .bus(if_c));

  typedef struct {
    logic busy;
    logic stable;
    logic sw;
    logic target;
    int   ec;
    int   start;
  } model_t;

  // Event timing from the start cycle: tick j lands at start + j*tm.
  function automatic model_t mstep(input model_t m, input int k, input logic req,
                                   input logic l0, input int tm, input int b, input int s);
    model_t n = m;
    if (!m.busy) begin
      n.sw = m.stable;
      if (req != m.stable) begin
        n.busy = 1'b1; n.target = req; n.start = k; n.ec = 0;
      end
    end else begin
      int   d = k - m.start;
      logic v;
      if (d % tm == 0) begin
        int j = d / tm;
        if (j <= b) begin
          v = (j == 1 || j == b) ? m.target : l0;
          if (v != m.sw && n.ec < 255) n.ec = n.ec + 1;
          n.sw = v;
        end
        if (j == b + s) begin
          n.stable = m.target;
          n.busy   = 1'b0;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic sw, input logic busy,
                                       input logic stable, input logic [7:0] ec);
    return {21'd0, sw, busy, stable, ec};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic   l0;
    model_t m;
    int     changes;
    int     gap;
    int     guard;

    reset = 1'b1;
    if_a.req_level = 1'b0;
    if_b.req_level = 1'b0;
    if_c.req_level = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Quiet line after reset.
    for (int i = 0; i < 100; i++) begin
      chk("idle_a", pack(if_a.sw_out, if_a.busy, if_a.stable_level, if_a.edge_count), 32'd0);
      @(negedge clk);
    end

    // Rising request on A (TICK_M=4, BOUNCE=3, SETTLE=2), sampled this cycle.
    l0 = 1'b0;
    if_a.req_level = 1'b1;
    for (int d = 1; d <= 24; d++) begin
      @(negedge clk);
      chk("t2_busy", 32'(if_a.busy), 32'(d <= 20));
      chk("t2_stable", 32'(if_a.stable_level), 32'(d >= 21));
      if (d == 8) l0 = m_lfsr[0];
      if (d < 5)        chk("t2_sw_pre", 32'(if_a.sw_out), 32'd0);
      else if (d == 5)  chk("t2_sw_first", 32'(if_a.sw_out), 32'd1);
      else if (d == 9)  chk("t2_sw_chatter", 32'(if_a.sw_out), 32'(l0));
      else if (d >= 13) chk("t2_sw_final", 32'(if_a.sw_out), 32'd1);
      if (d == 1)  chk("t2_ec_clear", 32'(if_a.edge_count), 32'd0);
      if (d == 21) chk("t2_ec", 32'(if_a.edge_count), l0 ? 32'd1 : 32'd3);
    end

    // Falling request on A with req toggling during bounce; target 0 kept.
    if_a.req_level = 1'b0;
    for (int d = 1; d <= 24; d++) begin
      @(negedge clk);
      if (d == 5)  chk("t3_sw_first", 32'(if_a.sw_out), 32'd0);
      if (d == 12) chk("t3_busy_mid", 32'(if_a.busy), 32'd1);
      if (d == 13) chk("t3_sw_final", 32'(if_a.sw_out), 32'd0);
      if (d == 21) chk("t3_done", {30'd0, if_a.busy, if_a.stable_level}, 32'd0);
      if (d >= 22) chk("t3_no_new", 32'(if_a.busy), 32'd0);
      if (d == 1)  if_a.req_level = 1'b1;
      if (d == 4)  if_a.req_level = 1'b0;
      if (d == 7)  if_a.req_level = 1'b1;
      if (d == 10) if_a.req_level = 1'b0;
    end

    // Request still differing at return to IDLE restarts on the next cycle.
    if_a.req_level = 1'b1;
    for (int d = 1; d <= 42; d++) begin
      @(negedge clk);
      if (d == 3)  if_a.req_level = 1'b0;
      if (d == 21) chk("t3b_idle", {30'd0, if_a.busy, if_a.stable_level}, 32'd1);
      if (d == 22) chk("t3b_restart", 32'(if_a.busy), 32'd1);
      if (d == 41) chk("t3b_busy2", 32'(if_a.busy), 32'd1);
      if (d == 42) chk("t3b_done2", {30'd0, if_a.busy, if_a.stable_level}, 32'd0);
    end

    // Single-tick bounce on B: one clean edge.
    if_b.req_level = 1'b1;
    for (int d = 1; d <= 13; d++) begin
      @(negedge clk);
      if (d == 4)  chk("t4_sw_pre", 32'(if_b.sw_out), 32'd0);
      if (d == 5)  chk("t4_edge", pack(if_b.sw_out, if_b.busy, if_b.stable_level, if_b.edge_count),
                       pack(1'b1, 1'b1, 1'b0, 8'd1));
      if (d == 12) chk("t4_hold", pack(if_b.sw_out, if_b.busy, if_b.stable_level, if_b.edge_count),
                       pack(1'b1, 1'b1, 1'b0, 8'd1));
      if (d == 13) chk("t4_done", pack(if_b.sw_out, if_b.busy, if_b.stable_level, if_b.edge_count),
                       pack(1'b1, 1'b0, 1'b1, 8'd1));
    end

    // Reset pulse while A is in SETTLE.
    if_a.req_level = 1'b1;
    for (int d = 1; d <= 15; d++) begin
      @(negedge clk);
      if (d == 14) chk("t5_pre", pack(if_a.sw_out, if_a.busy, 1'b0, 8'd0),
                       pack(1'b1, 1'b1, 1'b0, 8'd0));
    end
    reset = 1'b1;
    if_a.req_level = 1'b0;
    if_b.req_level = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_outs", pack(if_a.sw_out, if_a.busy, if_a.stable_level, if_a.edge_count), 32'd0);
    chk("t5_state", 32'(dut_a.state_q), 32'(IDLE));
    chk("t5_lfsr", 32'(dut_a.lfsr), 32'h0000ACE1);

    // Random request changes on C, checked every cycle against the model.
    m = '{busy: 1'b0, stable: 1'b0, sw: 1'b0, target: 1'b0, ec: 0, start: 0};
    changes = 0;
    guard = 0;
    gap = $urandom_range(1, 40);
    while (changes < 200 && guard < 40000) begin
      chk("rand_c", pack(if_c.sw_out, if_c.busy, if_c.stable_level, if_c.edge_count),
          pack(m.sw, m.busy, m.stable, m.ec[7:0]));
      if (gap == 0) begin
        if_c.req_level = ~if_c.req_level;
        changes++;
        gap = $urandom_range(1, 40);
      end else begin
        gap--;
      end
      m = mstep(m, cyc, if_c.req_level, m_lfsr[0], 2, 8, 4);
      guard++;
      @(negedge clk);
    end
    chk("rand_changes", 32'(changes), 32'd200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
